packet_snoop_fill: RTL and testbench
====================================

PACKET_SNOOP_FILL -- requirements
Module: packet_snoop_fill

Interface
REQ-001 SHALL have parameter SNOOP_FWD_ADDR_WIDTH, default 9: word address width of the packet buffer; depth is 2^SNOOP_FWD_ADDR_WIDTH 32-bit words.
REQ-002 SHALL define PLEN_WIDTH = SNOOP_FWD_ADDR_WIDTH+1 as a derived local width, not an overridable parameter.
REQ-003 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have snoop_data  input  32  incoming packet word.
REQ-006 SHALL have snoop_valid  input  1  snoop_data is valid.
REQ-007 SHALL have snoop_last  input  1  current word is the packet's final word.
REQ-008 SHALL have snoop_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have mem_wr_en  output  1  packet buffer write strobe.
REQ-010 SHALL have mem_wr_addr  output  SNOOP_FWD_ADDR_WIDTH  packet buffer word address.
REQ-011 SHALL have mem_wr_data  output  32  packet buffer write data.
REQ-012 SHALL have mem_ready  output  1  complete packet in buffer, CPU may run.
REQ-013 SHALL have packet_len  output  PLEN_WIDTH  count of words stored.
REQ-014 SHALL have truncated  output  1  stored packet was cut at buffer depth.
REQ-015 SHALL have cpu_acc  input  1  CPU accept verdict (one-cycle pulse).
REQ-016 SHALL have cpu_rej  input  1  CPU reject verdict (one-cycle pulse).
REQ-017 SHALL have acc_count  output  16  accepted packet counter.
REQ-018 SHALL have rej_count  output  16  rejected packet counter.

Function
REQ-019 SHALL implement FSM states IDLE, FILL, DROP, CPU_WAIT.
REQ-020 Beat = snoop_valid & snoop_ready on a rising edge.
REQ-021 snoop_ready SHALL be 1 in IDLE, FILL, DROP; 0 in CPU_WAIT.
REQ-022 In IDLE/FILL, mem_wr_en SHALL equal snoop_valid & snoop_ready combinationally, with mem_wr_data = snoop_data and mem_wr_addr = word count low bits (0 in IDLE); no write in DROP or CPU_WAIT.
REQ-023 Word count (PLEN_WIDTH bits) SHALL increment by 1 per written beat and SHALL be 0 in IDLE.
REQ-024 IDLE: beat with snoop_last -> CPU_WAIT; beat without snoop_last -> FILL.
REQ-025 FILL: beat with snoop_last -> CPU_WAIT; beat making count equal 2^SNOOP_FWD_ADDR_WIDTH without snoop_last -> DROP, truncated set to 1.
REQ-026 DROP: beats consumed and discarded, count frozen; beat with snoop_last -> CPU_WAIT.
REQ-027 Count SHALL never exceed 2^SNOOP_FWD_ADDR_WIDTH; a last beat landing exactly on the final address SHALL NOT set truncated.
REQ-028 mem_ready SHALL be registered: 1 exactly while in CPU_WAIT, i.e. first high the cycle after the last beat.
REQ-029 packet_len SHALL equal the word count and be stable throughout CPU_WAIT.
REQ-030 CPU_WAIT: cpu_acc -> acc_count+1, IDLE; cpu_rej (without cpu_acc) -> rej_count+1, IDLE; both together -> treated as accept only.
REQ-031 On return to IDLE, count and truncated SHALL clear in the same edge.
REQ-032 cpu_acc/cpu_rej outside CPU_WAIT SHALL be ignored (no counter or state change).
REQ-033 acc_count/rej_count SHALL wrap modulo 2^16.
REQ-034 snoop_valid low for any number of cycles mid-packet SHALL hold state and count.

Reset
REQ-035 While rst=0, SHALL force state IDLE, count 0, truncated 0, mem_ready 0, acc_count 0, rej_count 0, regardless of clk.
REQ-036 Reset mid-packet SHALL discard the partial packet; after release the next beat writes address 0.

Verification
REQ-037 3-word packet A,B,C (last on C) -> writes addr 0,1,2; mem_ready=1 next cycle; packet_len=3; truncated=0; snoop_ready=0.
REQ-038 Single-word packet (valid+last in IDLE) -> one write addr 0; packet_len=1; cpu_rej pulse -> rej_count=1, IDLE, packet_len=0.
REQ-039 SNOOP_FWD_ADDR_WIDTH=2, 6-word packet -> writes addr 0..3 only, words 5-6 discarded, packet_len=4, truncated=1; 4-word packet -> packet_len=4, truncated=0.
REQ-040 cpu_acc and cpu_rej high same cycle in CPU_WAIT -> acc_count+1, rej_count unchanged, IDLE.
REQ-041 cpu_acc pulse in IDLE and FILL -> counters and state unchanged.
REQ-042 rst=0 asynchronously after 2 of 5 words -> immediate IDLE, count 0; next packet starts at addr 0 with correct packet_len.

Source files
------------

// File: rtl/packet_snoop_fill.sv
// packet_snoop_fill: captures one snooped packet into a word-addressed buffer,
// truncating at buffer depth, then holds it for a CPU accept/reject verdict.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   snoop_data/valid/last - incoming packet stream; snoop_ready is the handshake
//   mem_wr_en/addr/data  - packet buffer write port (combinational strobe)
//   mem_ready            - registered, high while a complete packet waits for the CPU
//   packet_len           - words stored for the current packet
//   truncated            - packet was cut at buffer depth
//   cpu_acc, cpu_rej     - CPU verdict pulses, honoured only while mem_ready
//   acc_count, rej_count - wrapping verdict counters
module packet_snoop_fill #(
  parameter int unsigned SNOOP_FWD_ADDR_WIDTH = 9,
  localparam int unsigned PLEN_WIDTH = SNOOP_FWD_ADDR_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     snoop_data,
  input  logic                            snoop_valid,
  input  logic                            snoop_last,
  output logic                            snoop_ready,
  output logic                            mem_wr_en,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]                     mem_wr_data,
  output logic                            mem_ready,
  output logic [PLEN_WIDTH-1:0]           packet_len,
  output logic                            truncated,
  input  logic                            cpu_acc,
  input  logic                            cpu_rej,
  output logic [15:0]                     acc_count,
  output logic [15:0]                     rej_count
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [PLEN_WIDTH-1:0] DEPTH = PLEN_WIDTH'(1) << SNOOP_FWD_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL     = 2'd1,
    S_DROP     = 2'd2,
    S_CPU_WAIT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PLEN_WIDTH-1:0]  count_q, count_d, count_inc;
  logic                   trunc_d;
  logic [CNT_WIDTH-1:0]   acc_d, rej_d;
  logic                   beat;

  assign beat      = snoop_valid & snoop_ready;
  assign count_inc = count_q + PLEN_WIDTH'(1);

  // Buffer write port: only IDLE/FILL store words; count is 0 in IDLE so addr is 0.
  assign mem_wr_en   = beat & ((state_q == S_IDLE) | (state_q == S_FILL));
  assign mem_wr_addr = count_q[SNOOP_FWD_ADDR_WIDTH-1:0];
  assign mem_wr_data = snoop_data;

  assign packet_len = count_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    trunc_d = truncated;
    acc_d   = acc_count;
    rej_d   = rej_count;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (beat) begin
          count_d = count_inc;
          if (snoop_last) begin
            state_d = S_CPU_WAIT;
          end else if (count_inc == DEPTH) begin
            // Buffer full with more words coming: swallow the rest.
            state_d = S_DROP;
            trunc_d = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_DROP: begin
        if (beat && snoop_last) state_d = S_CPU_WAIT;
      end
      S_CPU_WAIT: begin
        // Accept wins when both verdicts arrive together.
        if (cpu_acc || cpu_rej) begin
          if (cpu_acc) acc_d = acc_count + CNT_WIDTH'(1);
          else         rej_d = rej_count + CNT_WIDTH'(1);
          state_d = S_IDLE;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered datapath and handshake outputs, derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      truncated   <= 1'b0;
      mem_ready   <= 1'b0;
      snoop_ready <= 1'b1;
      acc_count   <= '0;
      rej_count   <= '0;
    end else begin
      count_q     <= count_d;
      truncated   <= trunc_d;
      mem_ready   <= (state_d == S_CPU_WAIT);
      snoop_ready <= (state_d != S_CPU_WAIT);
      acc_count   <= acc_d;
      rej_count   <= rej_d;
    end
  end

endmodule

// File: tb/tb_packet_snoop_fill.sv
// Self-checking bench for packet_snoop_fill with a 4-word buffer.
module tb_packet_snoop_fill;

  localparam int AW    = 2;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   snoop_data = '0;
  logic          snoop_valid = 1'b0;
  logic          snoop_last = 1'b0;
  logic          snoop_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_ready;
  logic [PW-1:0] packet_len;
  logic          truncated;
  logic          cpu_acc = 1'b0;
  logic          cpu_rej = 1'b0;
  logic [15:0]   acc_count;
  logic [15:0]   rej_count;

  int checks = 0;
  int failures = 0;
  int exp_acc = 0;
  int exp_rej = 0;

  packet_snoop_fill #(.SNOOP_FWD_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .snoop_data(snoop_data), .snoop_valid(snoop_valid), .snoop_last(snoop_last),
    .snoop_ready(snoop_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_ready(mem_ready), .packet_len(packet_len), .truncated(truncated),
    .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .acc_count(acc_count), .rej_count(rej_count)
  );

  always #5 clk = ~clk;

  // Drives one packet of len words with optional idle gaps (and stray verdict
  // pulses when noise is set); checks every write against the expected layout.
  task automatic send_packet(input int len, input int max_gap, input bit noise);
    int gap;
    int held;
    int exp_len;
    logic [31:0] d;
    exp_len = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < len; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      held = (i > DEPTH) ? DEPTH : i;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        snoop_valid = 1'b0; snoop_data = $urandom; snoop_last = 1'($urandom);
        cpu_acc = noise ? 1'($urandom) : 1'b0;
        cpu_rej = noise ? 1'($urandom) : 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL gap_wr_en word%0d got=%0b exp=0", i, mem_wr_en); end
        checks++;
        if (packet_len !== PW'(held)) begin failures++; $display("FAIL gap_len word%0d got=%0d exp=%0d", i, packet_len, held); end
      end
      @(negedge clk);
      d = $urandom;
      snoop_valid = 1'b1; snoop_data = d; snoop_last = (i == len - 1);
      cpu_acc = 1'b0; cpu_rej = 1'b0;
      #1;
      checks++;
      if (snoop_ready !== 1'b1) begin failures++; $display("FAIL beat_ready word%0d got=%0b exp=1", i, snoop_ready); end
      checks++;
      if (mem_wr_en !== (i < DEPTH)) begin failures++; $display("FAIL beat_wr_en word%0d got=%0b exp=%0b", i, mem_wr_en, (i < DEPTH)); end
      if (i < DEPTH) begin
        checks++;
        if (mem_wr_addr !== AW'(i)) begin failures++; $display("FAIL beat_addr word%0d got=%0d exp=%0d", i, mem_wr_addr, i); end
        checks++;
        if (mem_wr_data !== d) begin failures++; $display("FAIL beat_data word%0d got=%08h exp=%08h", i, mem_wr_data, d); end
      end
    end
    @(negedge clk);
    snoop_valid = 1'b0; snoop_last = 1'b0;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL done_mem_ready len%0d got=%0b exp=1", len, mem_ready); end
    checks++;
    if (packet_len !== PW'(exp_len)) begin failures++; $display("FAIL done_len len%0d got=%0d exp=%0d", len, packet_len, exp_len); end
    checks++;
    if (truncated !== (len > DEPTH)) begin failures++; $display("FAIL done_trunc len%0d got=%0b exp=%0b", len, truncated, (len > DEPTH)); end
    checks++;
    if (snoop_ready !== 1'b0) begin failures++; $display("FAIL done_ready len%0d got=%0b exp=0", len, snoop_ready); end
  endtask

  // Holds in CPU_WAIT for waitc cycles with stray stream traffic, then issues a verdict.
  task automatic verdict(input int waitc, input bit a, input bit r, input int plen, input bit tr);
    repeat (waitc) begin
      @(negedge clk);
      snoop_valid = 1'($urandom); snoop_data = $urandom; snoop_last = 1'($urandom);
      #1;
      checks++;
      if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL wait_wr_en got=%0b exp=0", mem_wr_en); end
      checks++;
      if (mem_ready !== 1'b1 || packet_len !== PW'(plen) || truncated !== tr) begin
        failures++;
        $display("FAIL wait_hold got=%0b/%0d/%0b exp=1/%0d/%0b", mem_ready, packet_len, truncated, plen, tr);
      end
    end
    @(negedge clk);
    snoop_valid = 1'b0; snoop_last = 1'b0; cpu_acc = a; cpu_rej = r;
    @(negedge clk);
    cpu_acc = 1'b0; cpu_rej = 1'b0;
    if (a)      exp_acc = (exp_acc + 1) % 65536;
    else if (r) exp_rej = (exp_rej + 1) % 65536;
    #1;
    checks++;
    if (mem_ready !== 1'b0 || packet_len !== '0 || truncated !== 1'b0 || snoop_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_verdict got=%0b/%0d/%0b/%0b exp=0/0/0/1", mem_ready, packet_len, truncated, snoop_ready);
    end
    checks++;
    if (acc_count !== 16'(exp_acc)) begin failures++; $display("FAIL acc_count got=%0d exp=%0d", acc_count, exp_acc); end
    checks++;
    if (rej_count !== 16'(exp_rej)) begin failures++; $display("FAIL rej_count got=%0d exp=%0d", rej_count, exp_rej); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (snoop_ready !== 1'b1 || mem_ready !== 1'b0 || packet_len !== '0 || truncated !== 1'b0 || mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%0b/%0b/%0d/%0b/%0b exp=1/0/0/0/0", snoop_ready, mem_ready, packet_len, truncated, mem_wr_en);
    end
    checks++;
    if (acc_count !== 16'd0 || rej_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", acc_count, rej_count); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_three_word();
    send_packet(3, 0, 1'b0);
    verdict(2, 1'b1, 1'b0, 3, 1'b0);
  endtask

  task automatic test_single_reject();
    send_packet(1, 0, 1'b0);
    verdict(0, 1'b0, 1'b1, 1, 1'b0);
  endtask

  task automatic test_truncate();
    send_packet(6, 0, 1'b0);
    verdict(3, 1'b1, 1'b0, DEPTH, 1'b1);
    send_packet(DEPTH, 0, 1'b0);
    verdict(1, 1'b0, 1'b1, DEPTH, 1'b0);
    send_packet(DEPTH + 1, 1, 1'b0);
    verdict(1, 1'b1, 1'b0, DEPTH, 1'b1);
  endtask

  task automatic test_both_verdicts();
    send_packet(2, 0, 1'b0);
    verdict(1, 1'b1, 1'b1, 2, 1'b0);
  endtask

  task automatic test_ignored_verdicts();
    send_packet(3, 3, 1'b1);
    verdict(0, 1'b0, 1'b1, 3, 1'b0);
    send_packet(7, 2, 1'b1);
    verdict(2, 1'b1, 1'b0, DEPTH, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      snoop_valid = 1'b1; snoop_data = $urandom; snoop_last = 1'b0;
    end
    @(negedge clk);
    snoop_valid = 1'b0;
    #1;
    checks++;
    if (packet_len !== PW'(2)) begin failures++; $display("FAIL pre_reset_len got=%0d exp=2", packet_len); end
    #1;
    rst = 1'b0;
    exp_acc = 0;
    exp_rej = 0;
    #1;
    checks++;
    if (packet_len !== '0 || mem_ready !== 1'b0 || snoop_ready !== 1'b1 || truncated !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%0d/%0b/%0b/%0b exp=0/0/1/0", packet_len, mem_ready, snoop_ready, truncated);
    end
    checks++;
    if (acc_count !== 16'd0 || rej_count !== 16'd0) begin failures++; $display("FAIL async_reset_counts got=%0d/%0d exp=0/0", acc_count, rej_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_packet(3, 0, 1'b0);
    verdict(0, 1'b1, 1'b0, 3, 1'b0);
  endtask

  task automatic test_random();
    int len;
    int kind;
    for (int p = 0; p < 30; p++) begin
      len  = int'($urandom_range(2 * DEPTH, 1));
      kind = int'($urandom_range(2, 0));
      send_packet(len, 2, 1'($urandom));
      verdict(int'($urandom_range(3, 0)), (kind != 1), (kind != 0), (len > DEPTH) ? DEPTH : len, (len > DEPTH));
    end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_single_reject();
    test_truncate();
    test_both_verdicts();
    test_ignored_verdicts();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
